// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- common-data-bus arbiter.
// Buffers completed results from NUM_UNITS execution units, one small FIFO per
// channel, and broadcasts one result per cycle on a registered CDB.
// Arbitration is round-robin by default. Defining CDB_AGE_PRIORITY_EN switches
// it to oldest-first by ROB age relative to rob_head.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of all buffered results
//   rob_head              ROB head tag (age arbitration only)
//   unit_valid/tag/data   per-unit result inputs, unit i at [i*W +: W]
//   unit_ack              per-unit accept (state only: !full && !flush)
//   cdb_valid/tag/data    registered broadcast
//   cdb_src               index of the winning unit
//   buf_count             per-channel occupancy, packed like unit_tag
//   pending               any channel non-empty
module cdb_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        flush,
  input  logic [TAG_WIDTH-1:0]                        rob_head,
  input  logic [NUM_UNITS-1:0]                        unit_valid,
  input  logic [NUM_UNITS*TAG_WIDTH-1:0]              unit_tag,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]             unit_data,
  output logic [NUM_UNITS-1:0]                        unit_ack,
  output logic                                        cdb_valid,
  output logic [TAG_WIDTH-1:0]                        cdb_tag,
  output logic [DATA_WIDTH-1:0]                       cdb_data,
  output logic [$clog2(NUM_UNITS)-1:0]                cdb_src,
  output logic [NUM_UNITS*($clog2(BUF_DEPTH)+1)-1:0]  buf_count,
  output logic                                        pending
);

  localparam int SRC_W = $clog2(NUM_UNITS);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_WIDTH-1:0]  tag_mem  [NUM_UNITS][BUF_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [NUM_UNITS][BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr   [NUM_UNITS];
  logic [PTR_W-1:0]      wr_ptr   [NUM_UNITS];
  logic [CNT_W-1:0]      count    [NUM_UNITS];
  logic [TAG_WIDTH-1:0]  head_tag [NUM_UNITS];
  logic [DATA_WIDTH-1:0] head_data[NUM_UNITS];

  logic [NUM_UNITS-1:0]  nonempty;
  logic [NUM_UNITS-1:0]  full;
  logic [NUM_UNITS-1:0]  push;
  logic [NUM_UNITS-1:0]  pop;
  logic                  grant;
  logic [SRC_W-1:0]      win;

  // Channel status and handshakes. Ack is derived from registered occupancy
  // only, so a full channel stays closed even while its head is being popped.
  always_comb begin
    nonempty  = '0;
    full      = '0;
    unit_ack  = '0;
    push      = '0;
    pop       = '0;
    buf_count = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      head_tag[i]  = tag_mem[i][rd_ptr[i]];
      head_data[i] = data_mem[i][rd_ptr[i]];
      nonempty[i]  = (count[i] != '0);
      full[i]      = (count[i] == CNT_W'(BUF_DEPTH));
      unit_ack[i]  = !full[i] && !flush;
      push[i]      = unit_valid[i] && unit_ack[i];
      pop[i]       = grant && !flush && (win == SRC_W'(i));
      buf_count[i*CNT_W +: CNT_W] = count[i];
    end
  end

  assign pending = |nonempty;

`ifdef CDB_AGE_PRIORITY_EN
  logic [TAG_WIDTH-1:0] age;
  logic [TAG_WIDTH-1:0] best_age;

  // Oldest-first: age wraps modulo 2^TAG_WIDTH; strict compare keeps ties on
  // the lowest channel index.
  always_comb begin
    grant    = 1'b0;
    win      = '0;
    age      = '0;
    best_age = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      age = head_tag[k] - rob_head;
      if (nonempty[k] && (!grant || age < best_age)) begin
        grant    = 1'b1;
        win      = SRC_W'(k);
        best_age = age;
      end
    end
  end
`else
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] idx;
  logic             unused_rob_head;

  assign unused_rob_head = ^rob_head;

  // Round-robin: first non-empty channel at or after rr_ptr.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      idx = SRC_W'((32'(rr_ptr) + k) % NUM_UNITS);
      if (!grant && nonempty[idx]) begin
        grant = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (win == SRC_W'(NUM_UNITS - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (push[i]) begin
        tag_mem[i][wr_ptr[i]]  <= unit_tag[i*TAG_WIDTH +: TAG_WIDTH];
        data_mem[i][wr_ptr[i]] <= unit_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      cdb_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      cdb_valid <= grant;
      if (grant) begin
        cdb_tag  <= head_tag[win];
        cdb_data <= head_data[win];
        cdb_src  <= win;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter -- directed and randomized bench for cdb_arbiter with a
// queue-based reference model of the buffered results and the arbitration rule.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int BD = 2;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [TW-1:0]     rob_head;
  logic [N-1:0]      unit_valid;
  logic [N*TW-1:0]   unit_tag;
  logic [N*DW-1:0]   unit_data;
  logic [N-1:0]      unit_ack;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [1:0]        cdb_src;
  logic [N*CW-1:0]   buf_count;
  logic              pending;

  cdb_arbiter #(
    .NUM_UNITS (N),
    .TAG_WIDTH (TW),
    .DATA_WIDTH(DW),
    .BUF_DEPTH (BD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rob_head  (rob_head),
    .unit_valid(unit_valid),
    .unit_tag  (unit_tag),
    .unit_data (unit_data),
    .unit_ack  (unit_ack),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .buf_count (buf_count),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q [N][$];
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;
  int            m_rr;
  logic [TW-1:0] tg [N];
  logic [DW-1:0] dt [N];
  logic          saw_full;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_cdb();
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_tag",   64'(cdb_tag),   64'(m_tag));
    chk("cdb_data",  64'(cdb_data),  64'(m_data));
    chk("cdb_src",   64'(cdb_src),   64'(m_src));
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) q[i].delete();
    m_valid = 1'b0;
    m_rr    = 0;
  endtask

  // Reference winner: smallest wrapped age (lowest index on ties) when age
  // priority is compiled in, otherwise first occupied channel from m_rr.
  function automatic int model_winner();
    int best = -1;
`ifdef CDB_AGE_PRIORITY_EN
    int bage = 0;
    for (int u = 0; u < N; u++) begin
      if (q[u].size() > 0) begin
        int a = (int'(q[u][0].tag) - int'(rob_head)) & ((1 << TW) - 1);
        if (best < 0 || a < bage) begin
          best = u;
          bage = a;
        end
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      int u = (m_rr + k) % N;
      if (best < 0 && q[u].size() > 0) best = u;
    end
`endif
    return best;
  endfunction

  // One clock cycle: drive inputs, check pre-edge status, advance model and
  // check the registered CDB after the edge.
  task automatic step(input logic [N-1:0] v, input logic fl);
    int            w;
    logic [N-1:0]  ea;
    logic [N*CW-1:0] ebc;
    logic          ep;
    ent_t          e;
    unit_valid = v;
    flush      = fl;
    for (int i = 0; i < N; i++) begin
      unit_tag[i*TW +: TW]  = tg[i];
      unit_data[i*DW +: DW] = dt[i];
    end
    #1;
    ep = 1'b0;
    for (int i = 0; i < N; i++) begin
      ea[i] = (q[i].size() < BD) && !fl;
      ebc[i*CW +: CW] = CW'(q[i].size());
      ep = ep | (q[i].size() > 0);
    end
    chk("unit_ack",  64'(unit_ack),  64'(ea));
    chk("buf_count", 64'(buf_count), 64'(ebc));
    chk("pending",   64'(pending),   64'(ep));
    if (buf_count[CW-1:0] == 2'd2) saw_full = 1'b1;
    w = model_winner();
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_tag   = q[w][0].tag;
        m_data  = q[w][0].data;
        m_src   = 2'(w);
        void'(q[w].pop_front());
        m_rr    = (w + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && ea[i]) begin
          e.tag  = tg[i];
          e.data = dt[i];
          q[i].push_back(e);
        end
      end
    end
    #1;
    check_cdb();
  endtask

  // Asynchronous reset: outputs must return to reset values without a clock.
  task automatic do_reset();
    rst_n      = 1'b0;
    unit_valid = '0;
    flush      = 1'b0;
    #1;
    model_clear();
    m_tag  = '0;
    m_data = '0;
    m_src  = '0;
    check_cdb();
    chk("rst_buf_count", 64'(buf_count), 64'd0);
    chk("rst_pending",   64'(pending),   64'd0);
    chk("rst_unit_ack",  64'(unit_ack),  64'hF);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0);
  endtask

  initial begin
    logic [TW-1:0] exp_tags [5];
    rst_n      = 1'b1;
    flush      = 1'b0;
    rob_head   = '0;
    unit_valid = '0;
    unit_tag   = '0;
    unit_data  = '0;
    saw_full   = 1'b0;
    for (int i = 0; i < N; i++) begin
      tg[i] = '0;
      dt[i] = '0;
    end
    #1;
    do_reset();

    // Single push on unit 2.
    tg[2] = 4'd5;
    dt[2] = 32'hDEADBEEF;
    step(4'b0100, 1'b0);
    chk("t1_pre_valid", 64'(cdb_valid), 64'd0);
    step('0, 1'b0);
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_tag",   64'(cdb_tag),   64'd5);
    chk("t1_src",   64'(cdb_src),   64'd2);
    chk("t1_data",  64'(cdb_data),  64'hDEADBEEF);
    step('0, 1'b0);
    chk("t1_after_valid", 64'(cdb_valid), 64'd0);

    // Four simultaneous pushes then a second wave mid-drain.
    do_reset();
    for (int i = 0; i < N; i++) begin
      tg[i] = TW'(i + 1);
      dt[i] = $urandom;
    end
    step(4'b1111, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step('0, 1'b0);
      chk("t2_src", 64'(cdb_src), 64'(k));
    end
    for (int i = 0; i < N; i++) begin
      tg[i] = TW'(i + 5);
      dt[i] = $urandom;
    end
    step(4'b1111, 1'b0);
    chk("t2_wave_tag", 64'(cdb_tag), 64'd3);
    exp_tags[0] = 4'd4;
    exp_tags[1] = 4'd5;
    exp_tags[2] = 4'd6;
    exp_tags[3] = 4'd7;
    exp_tags[4] = 4'd8;
    for (int k = 0; k < 5; k++) begin
      step('0, 1'b0);
      chk("t2_rot_tag", 64'(cdb_tag), 64'(exp_tags[k]));
    end
    idle(2);

    // Unit 0 pushes every cycle against unit 1.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tg[0] = TW'($urandom);
      tg[1] = TW'($urandom);
      dt[0] = $urandom;
      dt[1] = $urandom;
      step(4'b0011, 1'b0);
    end
    chk("t3_full_seen", 64'(saw_full), 64'd1);
    idle(6);

    // Fill, then flush with inputs still asserted.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        tg[i] = TW'($urandom);
        dt[i] = $urandom;
      end
      step(4'b1111, 1'b0);
    end
    step(4'b0011, 1'b0);
    step(4'b1111, 1'b1);
    chk("t4_flush_count",   64'(buf_count), 64'd0);
    chk("t4_flush_pending", 64'(pending),   64'd0);
    chk("t4_flush_valid",   64'(cdb_valid), 64'd0);
    step('0, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        tg[i] = TW'($urandom);
        dt[i] = $urandom;
      end
      rob_head = TW'($urandom);
      step(N'($urandom), ($urandom_range(0, 19) == 0));
    end
    idle(8);

    // Reset mid-stream with three results buffered.
    for (int i = 0; i < N; i++) begin
      tg[i] = TW'(i + 9);
      dt[i] = $urandom;
    end
    step(4'b0111, 1'b0);
    chk("t6_buffered", 64'(buf_count), 64'h15);
    do_reset();
    idle(4);

`ifdef CDB_AGE_PRIORITY_EN
    do_reset();
    rob_head = 4'd14;
    tg[0] = 4'd3;
    tg[1] = 4'd15;
    step(4'b0011, 1'b0);
    step('0, 1'b0);
    chk("age_first_src",  64'(cdb_src), 64'd1);
    step('0, 1'b0);
    chk("age_second_src", 64'(cdb_src), 64'd0);
    tg[0] = 4'd0;
    tg[1] = 4'd13;
    step(4'b0011, 1'b0);
    step('0, 1'b0);
    chk("age_wrap_src", 64'(cdb_src), 64'd0);
    idle(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
